// File: rtl/imem_responder_pkg.sv
// Shared constants and types for the RV32I instruction-memory responder.
package rv32i_pkg;

    localparam logic [31:0] NOP_INST    = 32'h00000013;
    localparam int          IMEM_DEPTH  = 4096;
    localparam int          IMEM_ADDR_W = 12;

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } imem_state_t;

endpackage

// File: rtl/imem_responder_if.sv
// Fetch-side and image-load signals of the instruction memory.
// master = fetch stage / boot loader, slave = imem_responder.
interface imem_responder_if #(
    parameter int ADDR_W = 12
);
    logic [ADDR_W-1:0] instmem_adr;
    logic              stall;
    logic              flush;
    logic              ld_valid;
    logic [31:0]       ld_data;
    logic              ld_last;
    logic              ld_ready;
    logic [31:0]       inst;
    logic              inst_valid;
    logic              booted;
    logic [ADDR_W:0]   ld_count;

    modport master (
        output instmem_adr, stall, flush, ld_valid, ld_data, ld_last,
        input  ld_ready, inst, inst_valid, booted, ld_count
    );

    modport slave (
        input  instmem_adr, stall, flush, ld_valid, ld_data, ld_last,
        output ld_ready, inst, inst_valid, booted, ld_count
    );
endinterface

// File: rtl/imem_responder_sram.sv
// DEPTH x 32 synchronous 1R1W array, shaped to map onto a block RAM.
// rdata keeps its last value whenever re is low.
module imem_sram #(
    parameter int DEPTH  = 4096,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [31:0]       wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [31:0]       rdata
);

    logic [31:0] mem [DEPTH];

    // Registered write and enable-gated registered read.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: streams an image into the store after reset,
// then serves fetch addresses with one-cycle latency under stall/flush.
//
// state | meaning
// LOAD  | accepting image words on the load port, output forced to NOP
// RUN   | serving fetch reads, load port closed
module imem_responder
    import rv32i_pkg::*;
#(
    parameter int DEPTH     = IMEM_DEPTH,
    parameter int ADDR_W    = IMEM_ADDR_W,
    parameter bit BOOT_LOAD = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    imem_responder_if.slave  bus
);

    localparam imem_state_t       RESET_STATE = BOOT_LOAD ? LOAD : RUN;
    localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   FULL_COUNT  = (ADDR_W + 1)'(DEPTH);

    imem_state_t       state_q;
    imem_state_t       state_d;
    logic [ADDR_W-1:0] ld_ptr_q;
    logic [ADDR_W:0]   ld_count_q;
    logic              ld_fire;
    logic              rd_en;
    logic              nop_q;
    logic              inst_valid_q;
    logic [31:0]       rdata;

    // Next state, load handshake and read enable.
    always_comb begin
        state_d = state_q;
        ld_fire = 1'b0;
        rd_en   = 1'b0;
        case (state_q)
            LOAD: begin
                ld_fire = bus.ld_valid;
                if (ld_fire && (bus.ld_last || ld_ptr_q == LAST_ADDR)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                // A stalled or flushed cycle leaves the array output untouched.
                rd_en = !bus.flush && !bus.stall;
            end
            default: state_d = RESET_STATE;
        endcase
    end

    // State register plus load pointer and saturating word counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RESET_STATE;
            ld_ptr_q   <= '0;
            ld_count_q <= '0;
        end else begin
            state_q <= state_d;
            if (ld_fire) begin
                ld_ptr_q <= ld_ptr_q + 1'b1;
                if (ld_count_q != FULL_COUNT) begin
                    ld_count_q <= ld_count_q + 1'b1;
                end
            end
        end
    end

    // Output qualifier: the array's own read register is the data stage,
    // so flush only needs to mask it with NOP and drop valid.
    always_ff @(posedge clk) begin
        if (reset || state_q == LOAD) begin
            nop_q        <= 1'b1;
            inst_valid_q <= 1'b0;
        end else if (bus.flush) begin
            nop_q        <= 1'b1;
            inst_valid_q <= 1'b0;
        end else if (!bus.stall) begin
            nop_q        <= 1'b0;
            inst_valid_q <= 1'b1;
        end
    end

    imem_sram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_sram (
        .clk   (clk),
        .we    (ld_fire),
        .waddr (ld_ptr_q),
        .wdata (bus.ld_data),
        .re    (rd_en),
        .raddr (bus.instmem_adr),
        .rdata (rdata)
    );

    assign bus.inst       = nop_q ? NOP_INST : rdata;
    assign bus.inst_valid = inst_valid_q;
    assign bus.booted     = (state_q == RUN);
    assign bus.ld_ready   = (state_q == LOAD);
    assign bus.ld_count   = ld_count_q;

endmodule

// File: tb/tb_imem_responder.sv
// Randomized scoreboard bench for imem_responder (BOOT_LOAD = 1).
module tb_imem_responder;
    import rv32i_pkg::*;

    localparam int DEPTH = 4096;
    localparam int AW    = 12;

    typedef struct {
        logic [31:0] inst;
        logic        valid;
        logic        booted;
        logic [AW:0] count;
    } exp_t;

    logic clk;
    logic reset;

    imem_responder_if #(.ADDR_W(AW)) bus ();

    imem_responder #(
        .DEPTH     (DEPTH),
        .ADDR_W    (AW),
        .BOOT_LOAD (1'b1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    // Reference model: image store, load progress and expected output.
    logic [31:0] m_mem [DEPTH];
    bit          m_loading;
    int          m_ptr;
    int          m_cnt;
    logic [31:0] m_inst;
    logic        m_valid;

    // Monitor: one expected record per driven cycle, compared after the edge.
    always @(posedge clk) begin
        exp_t e;
        #2;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (bus.inst !== e.inst) begin
                errors++;
                $display("FAIL inst t=%0t got %h expected %h", $time, bus.inst, e.inst);
            end
            checks++;
            if (bus.inst_valid !== e.valid) begin
                errors++;
                $display("FAIL inst_valid t=%0t got %b expected %b", $time, bus.inst_valid, e.valid);
            end
            checks++;
            if (bus.booted !== e.booted) begin
                errors++;
                $display("FAIL booted t=%0t got %b expected %b", $time, bus.booted, e.booted);
            end
            checks++;
            if (bus.ld_ready !== !e.booted) begin
                errors++;
                $display("FAIL ld_ready t=%0t got %b expected %b", $time, bus.ld_ready, !e.booted);
            end
            checks++;
            if (bus.ld_count !== e.count) begin
                errors++;
                $display("FAIL ld_count t=%0t got %0d expected %0d", $time, bus.ld_count, e.count);
            end
        end
    end

    // One clock of stimulus; the model advances and the expected result is queued.
    task automatic step(input logic [AW-1:0] adr, input logic st, input logic fl,
                        input logic v, input logic [31:0] d, input logic l);
        exp_t e;
        @(negedge clk);
        reset           = 1'b0;
        bus.instmem_adr = adr;
        bus.stall       = st;
        bus.flush       = fl;
        bus.ld_valid    = v;
        bus.ld_data     = d;
        bus.ld_last     = l;
        if (m_loading) begin
            if (v) begin
                m_mem[m_ptr] = d;
                m_ptr++;
                if (m_cnt < DEPTH) m_cnt++;
                if (l || m_cnt == DEPTH) m_loading = 0;
            end
            m_inst  = NOP_INST;
            m_valid = 1'b0;
        end else if (fl) begin
            m_inst  = NOP_INST;
            m_valid = 1'b0;
        end else if (!st) begin
            m_inst  = m_mem[adr];
            m_valid = 1'b1;
        end
        e.inst   = m_inst;
        e.valid  = m_valid;
        e.booted = !m_loading;
        e.count  = (AW + 1)'(m_cnt);
        sb.push_back(e);
        @(posedge clk);
    endtask

    task automatic load(input logic [31:0] d, input logic l);
        step('0, 1'b0, 1'b0, 1'b1, d, l);
    endtask

    task automatic rd(input logic [AW-1:0] adr, input logic st, input logic fl);
        step(adr, st, fl, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic expect_eq(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, want);
        end
    endtask

    // Reset for one edge and check the reset values directly.
    task automatic do_reset();
        @(negedge clk);
        reset        = 1'b1;
        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'b0;
        bus.stall    = 1'b0;
        bus.flush    = 1'b0;
        @(posedge clk);
        #3;
        expect_eq("rst_inst", bus.inst, NOP_INST);
        expect_eq("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
        expect_eq("rst_booted", 32'(bus.booted), 32'd0);
        expect_eq("rst_ld_ready", 32'(bus.ld_ready), 32'd1);
        expect_eq("rst_ld_count", 32'(bus.ld_count), 32'd0);
        m_loading = 1;
        m_ptr     = 0;
        m_cnt     = 0;
        m_inst    = NOP_INST;
        m_valid   = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout at %0t", $time);
        $fatal(1, "simulation time limit");
    end

    initial begin
        int n;
        reset           = 1'b1;
        bus.instmem_adr = '0;
        bus.stall       = 1'b0;
        bus.flush       = 1'b0;
        bus.ld_valid    = 1'b0;
        bus.ld_data     = '0;
        bus.ld_last     = 1'b0;

        // Four-word image, ld_last on the fourth.
        do_reset();
        load(32'h00500093, 1'b0);
        load(32'h00108133, 1'b0);
        load(32'h00000013, 1'b0);
        load(32'hFE000EE3, 1'b1);
        #3;
        expect_eq("boot_count4", 32'(bus.ld_count), 32'd4);
        expect_eq("boot_valid_low", 32'(bus.inst_valid), 32'd0);

        for (int i = 0; i < 4; i++) rd(AW'(i), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) rd(AW'(i), 1'b1, 1'b0);
        rd(AW'(2), 1'b0, 1'b0);
        rd(AW'(1), 1'b1, 1'b1);
        rd(AW'(3), 1'b1, 1'b0);
        rd(AW'(3), 1'b0, 1'b0);

        // Random traffic over the loaded words; load inputs must be ignored.
        for (int i = 0; i < 200; i++) begin
            step(AW'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 7) == 0), 1'($urandom), $urandom, 1'($urandom));
        end

        // Full image with a toggling ld_valid and no ld_last.
        do_reset();
        n = 0;
        while (m_loading && n < 20000) begin
            step(AW'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), $urandom, 1'b0);
            n++;
        end
        checks++;
        if (m_loading) begin
            errors++;
            $display("FAIL full_load got %0d words expected %0d", m_cnt, DEPTH);
        end
        for (int i = 0; i < 8; i++) load($urandom, 1'b0);
        for (int i = 0; i < 300; i++) begin
            step(AW'($urandom), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 7) == 0), 1'($urandom), $urandom, 1'b0);
        end
        rd(AW'(0), 1'b0, 1'b0);
        rd(AW'(DEPTH - 1), 1'b0, 1'b0);

        // Reset mid-load, then a one-word image.
        do_reset();
        load(32'hAAAA0001, 1'b0);
        load(32'hBBBB0002, 1'b0);
        do_reset();
        load(32'hCCCC0003, 1'b1);
        rd(AW'(0), 1'b0, 1'b0);
        rd(AW'(1), 1'b0, 1'b0);
        rd(AW'(2), 1'b0, 1'b0);
        rd(AW'(1), 1'b0, 1'b1);

        @(posedge clk);
        @(posedge clk);
        #3;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d left expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
